multi_alarmclock: RTL
=====================

MULTI_ALARMCLOCK -- requirements
Module: multi_alarmclock

Interface
REQ-001 SHALL have parameter NUM_ALARMS, default 2, number of independent alarm channels (range 1..4).
REQ-002 SHALL have parameter TICKS_PER_MIN, default 15360, clk cycles per clock minute.
REQ-003 SHALL have parameter SNOOZE_MIN, default 9, snooze length in minutes.
REQ-004 SHALL have parameter RING_MIN, default 5, minutes of unanswered ringing before auto-stop.
REQ-005 SHALL have port: clk  in  1  single clock, rising edge.
REQ-006 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port: alarm_button  in  1  level; show or set selected alarm.
REQ-008 SHALL have port: time_button  in  1  level; commit keypad entry to current time.
REQ-009 SHALL have port: keypad_buttons  in  10  one-hot digit keys, bit n = digit n.
REQ-010 SHALL have port: alarm_sel  in  $clog2(NUM_ALARMS) (min 1)  selected alarm channel.
REQ-011 SHALL have port: alarm_en  in  NUM_ALARMS  per-channel arm bit.
REQ-012 SHALL have port: snooze_button, stop_button  in  1 each  ring control.
REQ-013 SHALL have port: disp_digits  out  16  four BCD digits H1 H0 M1 M0, H1 in [15:12].
REQ-014 SHALL have port: disp_mode  out  2  0 time, 1 alarm, 2 entry.
REQ-015 SHALL have ports: alarm_out  out  1  ringing; ring_id  out  $clog2(NUM_ALARMS)  ringing channel.

Function
REQ-016 SHALL keep 24-hour BCD time; prescaler counts 0..TICKS_PER_MIN-1, minute increments on terminal count; 23:59 wraps to 00:00.
REQ-017 SHALL detect button and key presses on rising edge (registered previous value); levels held do not repeat.
REQ-018 SHALL accept a key edge only if exactly one keypad bit is high; multi-bit patterns ignored.
REQ-019 SHALL shift accepted digits into a 4-digit entry buffer MS-first, count 0..4; digits beyond 4 ignored.
REQ-020 SHALL, on time_button edge with count==4 and HH<=23, MM<=59, load time, clear prescaler, clear entry; invalid or count<4 -> clear entry only, time unchanged.
REQ-021 SHALL, on alarm_button edge with count==4 and valid value, load alarm[alarm_sel], clear entry; invalid -> clear entry only.
REQ-022 SHALL select display: count>0 -> entry (unentered digits 0), mode 2; else alarm_button high -> alarm[alarm_sel], mode 1; else time, mode 0.
REQ-023 SHALL evaluate alarm match only on minute increment: channel fires if alarm_en[i] and new time == alarm[i]; time loads never fire.
REQ-024 SHALL run ring FSM IDLE -> RINGING on match (lowest index wins, latched in ring_id); matches outside IDLE ignored.
REQ-025 SHALL in RINGING: alarm_out=1; snooze edge -> SNOOZE; stop edge -> IDLE; RING_MIN minute ticks -> IDLE; stop wins over snooze if simultaneous.
REQ-026 SHALL in SNOOZE: alarm_out=0; SNOOZE_MIN minute ticks -> RINGING (same ring_id); stop edge -> IDLE.
REQ-027 SHALL drop to IDLE when alarm_en[ring_id] deasserts in RINGING or SNOOZE.
REQ-028 SHALL update outputs registered, one cycle after the causing edge or tick.

Reset
REQ-029 SHALL on reset low: time 00:00, prescaler 0, all alarms 00:00, entry cleared, FSM IDLE, disp_digits 0, disp_mode 0, alarm_out 0, ring_id 0.
REQ-030 SHALL abort any ring/snooze/entry immediately when reset asserts mid-operation.

Structure
REQ-031 SHALL place bcd_time_t (four 4-bit digits), ring state enum, and DISP_* mode constants in package alarmclock_pkg.
REQ-032 SHALL instantiate one sub-module bcd_time_counter (prescaler + BCD minute/hour with load and wrap).

Verification
REQ-033 SHALL verify: reset, wait 6666240 cycles -> disp_digits 16'h0714, mode 0.
REQ-034 SHALL verify: keys 0,4,3,5 then time_button -> 16'h0435 next cycle, prescaler 0; keys 2,5,0,0 + time_button -> time unchanged.
REQ-035 SHALL verify: alarm_sel=1, keys 0,4,3,6, alarm_button; alarm_en=2'b10; after 15360 cycles -> alarm_out 1, ring_id 1.
REQ-036 SHALL verify: snooze while ringing -> alarm_out 0, rings again after 9*15360 cycles; stop -> IDLE.
REQ-037 SHALL verify: both channels set 06:00, enabled, time 05:59 -> ring_id 0; unanswered -> alarm_out 0 after 5 minutes.
REQ-038 SHALL verify: 23:59 + one minute -> 16'h0000; keypad 10'h018 ignored; reset during RINGING -> alarm_out 0.

Source files
------------

// File: rtl/multi_alarmclock_pkg.sv
// Shared types for the multi-channel alarm clock.
//   bcd_time_t     : HH:MM as four BCD digits, H1 in the top nibble
//   ring_state_t   : alarm ring controller states
//   DISP_*         : disp_mode encodings
//   bcd_time_valid : true when HH<=23 and MM<=59
//   bcd_time_inc   : advance one minute, 23:59 wraps to 00:00
package alarmclock_pkg;

  typedef struct packed {
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } bcd_time_t;

  typedef enum logic [1:0] {
    RING_IDLE    = 2'd0,
    RING_RINGING = 2'd1,
    RING_SNOOZE  = 2'd2
  } ring_state_t;

  localparam logic [1:0] DISP_TIME  = 2'd0;
  localparam logic [1:0] DISP_ALARM = 2'd1;
  localparam logic [1:0] DISP_ENTRY = 2'd2;

  function automatic logic bcd_time_valid(input bcd_time_t t);
    logic hours_ok;
    logic mins_ok;
    hours_ok = ((t.h1 < 4'd2) && (t.h0 <= 4'd9)) || ((t.h1 == 4'd2) && (t.h0 <= 4'd3));
    mins_ok  = (t.m1 <= 4'd5) && (t.m0 <= 4'd9);
    return hours_ok && mins_ok;
  endfunction

  function automatic bcd_time_t bcd_time_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.m0 != 4'd9) begin
      r.m0 = t.m0 + 4'd1;
    end else begin
      r.m0 = 4'd0;
      if (t.m1 != 4'd5) begin
        r.m1 = t.m1 + 4'd1;
      end else begin
        r.m1 = 4'd0;
        if ((t.h1 == 4'd2) && (t.h0 == 4'd3)) begin
          r.h1 = 4'd0;
          r.h0 = 4'd0;
        end else if (t.h0 == 4'd9) begin
          r.h0 = 4'd0;
          r.h1 = t.h1 + 4'd1;
        end else begin
          r.h0 = t.h0 + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_alarmclock_if.sv
// Link between the alarm clock control logic and its time counter.
//   load      : replace the current time with load_val and restart the minute
//   load_val  : time to load
//   next_time : time value the counter will hold after this clock edge
//   tick      : a minute increment happens at this clock edge
interface multi_alarmclock_if;
  alarmclock_pkg::bcd_time_t load_val;
  alarmclock_pkg::bcd_time_t next_time;
  logic                      load;
  logic                      tick;

  modport master (output load, load_val, input next_time, tick);
  modport slave  (input load, load_val, output next_time, tick);
endinterface

// File: rtl/multi_alarmclock_bcd_time_counter.sv
// Prescaled 24-hour BCD minute counter.
//   clk, reset : clock, asynchronous active-low reset
//   link       : load request in; next time value and minute tick out
module bcd_time_counter
  import alarmclock_pkg::*;
#(
  parameter int unsigned TICKS_PER_MIN = 15360
) (
  input  logic                      clk,
  input  logic                      reset,
  multi_alarmclock_if.slave         link
);

  localparam int unsigned PW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MIN - 1);

  logic [PW-1:0] presc_q, presc_d;
  bcd_time_t     time_q, time_d;
  logic          tick;

  // A load restarts the minute and suppresses the increment in the same cycle.
  always_comb begin
    presc_d = presc_q;
    time_d  = time_q;
    tick    = 1'b0;
    if (link.load) begin
      presc_d = '0;
      time_d  = link.load_val;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      time_d  = bcd_time_inc(time_q);
      tick    = 1'b1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      time_q  <= '0;
    end else begin
      presc_q <= presc_d;
      time_q  <= time_d;
    end
  end

  assign link.next_time = time_d;
  assign link.tick      = tick;

endmodule

// File: rtl/multi_alarmclock.sv
// Multi-channel alarm clock: keypad time/alarm entry, per-channel arming,
// ring / snooze / auto-stop controller, registered display outputs.
//   clk, reset        : clock, asynchronous active-low reset
//   alarm_button      : level; show selected alarm, edge commits entry to it
//   time_button       : edge commits entry to the current time
//   keypad_buttons    : one-hot digit keys
//   alarm_sel         : selected alarm channel
//   alarm_en          : per-channel arm bits
//   snooze_button,
//   stop_button       : ring control (edge sensitive)
//   disp_digits       : H1 H0 M1 M0 BCD
//   disp_mode         : DISP_TIME / DISP_ALARM / DISP_ENTRY
//   alarm_out, ring_id: ringing flag and the channel that rang
module multi_alarmclock
  import alarmclock_pkg::*;
#(
  parameter  int unsigned NUM_ALARMS    = 2,
  parameter  int unsigned TICKS_PER_MIN = 15360,
  parameter  int unsigned SNOOZE_MIN    = 9,
  parameter  int unsigned RING_MIN      = 5,
  localparam int unsigned SEL_W         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alarm_button,
  input  logic                  time_button,
  input  logic [9:0]            keypad_buttons,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  snooze_button,
  input  logic                  stop_button,
  output logic [15:0]           disp_digits,
  output logic [1:0]            disp_mode,
  output logic                  alarm_out,
  output logic [SEL_W-1:0]      ring_id
);

  localparam int unsigned MAX_MIN = (RING_MIN > SNOOZE_MIN) ? RING_MIN : SNOOZE_MIN;
  localparam int unsigned CW      = $clog2(MAX_MIN + 1);

  multi_alarmclock_if link ();

  bcd_time_counter #(.TICKS_PER_MIN(TICKS_PER_MIN)) u_time (
    .clk   (clk),
    .reset (reset),
    .link  (link)
  );

  logic        alarm_btn_q, alarm_btn_d, time_btn_q, time_btn_d;
  logic        snooze_btn_q, snooze_btn_d, stop_btn_q, stop_btn_d;
  logic [9:0]  keypad_q, keypad_d;
  bcd_time_t   entry_q, entry_d;
  logic [2:0]  count_q, count_d;
  bcd_time_t   alarm_q [NUM_ALARMS];
  bcd_time_t   alarm_d [NUM_ALARMS];
  ring_state_t state_q, state_d;
  logic [SEL_W-1:0] ring_id_q, ring_id_d;
  logic [CW-1:0]    min_cnt_q, min_cnt_d;
  logic [15:0] disp_digits_q, disp_digits_d;
  logic [1:0]  disp_mode_q, disp_mode_d;
  logic        alarm_out_q, alarm_out_d;

  logic        alarm_edge, time_edge, snooze_edge, stop_edge, key_ok;
  logic [3:0]  key_digit;
  logic        entry_ok, time_load;
  logic        match_any;
  logic [SEL_W-1:0] match_id;
  logic [(2**SEL_W)-1:0] en_ext;
  logic        ring_en;
  bcd_time_t   sel_alarm;

  always_comb begin
    alarm_btn_d  = alarm_button;
    time_btn_d   = time_button;
    snooze_btn_d = snooze_button;
    stop_btn_d   = stop_button;
    keypad_d     = keypad_buttons;
  end

  assign alarm_edge  = alarm_button  & ~alarm_btn_q;
  assign time_edge   = time_button   & ~time_btn_q;
  assign snooze_edge = snooze_button & ~snooze_btn_q;
  assign stop_edge   = stop_button   & ~stop_btn_q;
  // A key counts only when the pattern is a single key and that key is newly down.
  assign key_ok      = $onehot(keypad_buttons) && ((keypad_buttons & ~keypad_q) != 10'd0);

  always_comb begin
    key_digit = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (keypad_buttons[i]) key_digit = 4'(i);
    end
  end

  // Entry buffer and commit; a commit in the same cycle as a key drops the key.
  always_comb begin
    entry_d   = entry_q;
    count_d   = count_q;
    alarm_d   = alarm_q;
    time_load = 1'b0;
    entry_ok  = (count_q == 3'd4) && bcd_time_valid(entry_q);
    if (time_edge || alarm_edge) begin
      entry_d = '0;
      count_d = '0;
      if (time_edge && entry_ok) time_load = 1'b1;
      if (alarm_edge && entry_ok) begin
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
          if (SEL_W'(i) == alarm_sel) alarm_d[i] = entry_q;
        end
      end
    end else if (key_ok && (count_q < 3'd4)) begin
      entry_d = {entry_q[11:0], key_digit};
      count_d = count_q + 3'd1;
    end
  end

  assign link.load     = time_load;
  assign link.load_val = entry_q;

  always_comb begin
    match_any = 1'b0;
    match_id  = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (!match_any && alarm_en[i] && (link.next_time == alarm_d[i])) begin
        match_any = 1'b1;
        match_id  = SEL_W'(i);
      end
    end
  end

  always_comb begin
    en_ext                 = '0;
    en_ext[NUM_ALARMS-1:0] = alarm_en;
    ring_en                = en_ext[ring_id_q];
  end

  always_comb begin
    state_d   = state_q;
    ring_id_d = ring_id_q;
    min_cnt_d = min_cnt_q;
    case (state_q)
      RING_IDLE: begin
        if (link.tick && match_any) begin
          state_d   = RING_RINGING;
          ring_id_d = match_id;
          min_cnt_d = '0;
        end
      end
      RING_RINGING: begin
        if (!ring_en || stop_edge) begin
          state_d = RING_IDLE;
        end else if (snooze_edge) begin
          state_d   = RING_SNOOZE;
          min_cnt_d = '0;
        end else if (link.tick) begin
          if (min_cnt_q == CW'(RING_MIN - 1)) state_d = RING_IDLE;
          else                                min_cnt_d = min_cnt_q + CW'(1);
        end
      end
      RING_SNOOZE: begin
        if (!ring_en || stop_edge) begin
          state_d = RING_IDLE;
        end else if (link.tick) begin
          if (min_cnt_q == CW'(SNOOZE_MIN - 1)) begin
            state_d   = RING_RINGING;
            min_cnt_d = '0;
          end else begin
            min_cnt_d = min_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = RING_IDLE;
    endcase
    alarm_out_d = (state_d == RING_RINGING);
  end

  // Display is built from next-state values so it lands on the same edge as the change.
  always_comb begin
    sel_alarm = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (SEL_W'(i) == alarm_sel) sel_alarm = alarm_d[i];
    end
    if (count_d != 3'd0) begin
      disp_digits_d = entry_d;
      disp_mode_d   = DISP_ENTRY;
    end else if (alarm_button) begin
      disp_digits_d = sel_alarm;
      disp_mode_d   = DISP_ALARM;
    end else begin
      disp_digits_d = link.next_time;
      disp_mode_d   = DISP_TIME;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_btn_q   <= 1'b0;
      time_btn_q    <= 1'b0;
      snooze_btn_q  <= 1'b0;
      stop_btn_q    <= 1'b0;
      keypad_q      <= '0;
      entry_q       <= '0;
      count_q       <= '0;
      for (int unsigned i = 0; i < NUM_ALARMS; i++) alarm_q[i] <= '0;
      state_q       <= RING_IDLE;
      ring_id_q     <= '0;
      min_cnt_q     <= '0;
      disp_digits_q <= '0;
      disp_mode_q   <= DISP_TIME;
      alarm_out_q   <= 1'b0;
    end else begin
      alarm_btn_q   <= alarm_btn_d;
      time_btn_q    <= time_btn_d;
      snooze_btn_q  <= snooze_btn_d;
      stop_btn_q    <= stop_btn_d;
      keypad_q      <= keypad_d;
      entry_q       <= entry_d;
      count_q       <= count_d;
      alarm_q       <= alarm_d;
      state_q       <= state_d;
      ring_id_q     <= ring_id_d;
      min_cnt_q     <= min_cnt_d;
      disp_digits_q <= disp_digits_d;
      disp_mode_q   <= disp_mode_d;
      alarm_out_q   <= alarm_out_d;
    end
  end

  assign disp_digits = disp_digits_q;
  assign disp_mode   = disp_mode_q;
  assign alarm_out   = alarm_out_q;
  assign ring_id     = ring_id_q;

endmodule
